// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment display path: blank pattern, hex font, raw glyphs.
package seg_pkg;

  // Active-low "all segments off" pattern (gfedcba)
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Hex font, active-high gfedcba, entry n is the glyph for nibble n
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
  };

  // Raw glyphs the game blocks send with raw_mask set (bit7 unused)
  localparam logic [7:0] GLYPH_H    = 8'h76;
  localparam logic [7:0] GLYPH_E    = 8'h79;
  localparam logic [7:0] GLYPH_DASH = 8'h40;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-high gfedcba decoder.
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg_c
);

  // Font lookup
  assign o_seg_c = HEX_FONT[i_nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit common-anode 7-segment scanner with dead-time,
// frame-coherent input snapshot, per-digit blanking and blinking.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned DEAD_CYCLES  = 1000,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] digit0,
  input  logic [7:0] digit1,
  input  logic [7:0] digit2,
  input  logic [7:0] digit3,
  input  logic [3:0] raw_mask,
  input  logic [3:0] dp_in,
  input  logic [3:0] blank,
  input  logic [3:0] blink,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_start
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Parameter sanity: the anode gap must leave room for an active part
  if (DEAD_CYCLES >= SCAN_DIV) begin : g_bad_dead
    $error("seg_scan_driver: DEAD_CYCLES must be less than SCAN_DIV");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("seg_scan_driver: BLINK_FRAMES must be at least 1");
  end

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [BLK_W-1:0] r_blink_cnt;
  logic             r_phase_off;

  logic [3:0][6:0]  r_digits;
  logic [3:0]       r_raw;
  logic [3:0]       r_dp_req;
  logic [3:0]       r_blank;
  logic [3:0]       r_blink;
  logic             r_off_snap;

  logic [6:0]       r_seg;
  logic             r_dp;
  logic [3:0]       r_an;
  logic             r_frame_start;

  logic             w_snap;
  logic             w_dead;
  logic [3:0][6:0]  w_digits;
  logic [3:0]       w_raw;
  logic [3:0]       w_dp_req;
  logic [3:0]       w_blank;
  logic [3:0]       w_blink;
  logic             w_off;
  logic [6:0]       w_sel;
  logic [6:0]       w_hex;
  logic [6:0]       w_pattern;
  logic             w_dark;
  logic             w_unused_msb;

  // Bit7 of each digit byte carries no meaning in either display mode
  assign w_unused_msb = ^{digit3[7], digit2[7], digit1[7], digit0[7]};

  assign w_snap = (r_cnt == '0) && (r_idx == 2'd0);
  assign w_dead = (r_cnt < CNT_W'(DEAD_CYCLES));

  // In the snapshot cycle itself, use the values being captured so the
  // whole frame (including a zero-dead-time first slot) stays coherent
  assign w_digits = w_snap ? {digit3[6:0], digit2[6:0], digit1[6:0], digit0[6:0]} : r_digits;
  assign w_raw    = w_snap ? raw_mask    : r_raw;
  assign w_dp_req = w_snap ? dp_in       : r_dp_req;
  assign w_blank  = w_snap ? blank       : r_blank;
  assign w_blink  = w_snap ? blink       : r_blink;
  assign w_off    = w_snap ? r_phase_off : r_off_snap;

  assign w_sel     = w_digits[r_idx];
  assign w_pattern = w_raw[r_idx] ? w_sel : w_hex;
  assign w_dark    = w_blank[r_idx] | (w_blink[r_idx] & w_off);

  hex_to_seg7 u_font (
    .i_nibble (w_sel[3:0]),
    .o_seg_c  (w_hex)
  );

  // Slot counter and digit index
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (r_cnt == CNT_W'(SCAN_DIV - 1)) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Frame snapshot of all display inputs plus the blink phase for this frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_digits   <= '0;
      r_raw      <= '0;
      r_dp_req   <= '0;
      r_blank    <= '0;
      r_blink    <= '0;
      r_off_snap <= 1'b0;
    end else if (w_snap) begin
      r_digits   <= w_digits;
      r_raw      <= raw_mask;
      r_dp_req   <= dp_in;
      r_blank    <= blank;
      r_blink    <= blink;
      r_off_snap <= r_phase_off;
    end
  end

  // Blink frame counter and phase toggle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt <= '0;
      r_phase_off <= 1'b0;
    end else if (w_snap) begin
      if (r_blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
        r_blink_cnt <= '0;
        r_phase_off <= ~r_phase_off;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLK_W'(1);
      end
    end
  end

  // Registered display outputs; anode stays driven on dark digits to keep timing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_an          <= 4'hF;
      r_seg         <= SEG_OFF;
      r_dp          <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_snap;
      if (w_dead) begin
        r_an  <= 4'hF;
        r_seg <= SEG_OFF;
        r_dp  <= 1'b1;
      end else begin
        r_an  <= ~(4'b0001 << r_idx);
        r_seg <= w_dark ? SEG_OFF : ~w_pattern;
        r_dp  <= w_dark ? 1'b1 : ~w_dp_req[r_idx];
      end
    end
  end

  assign seg         = r_seg;
  assign dp          = r_dp;
  assign an          = r_an;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (SCAN_DIV=8, DEAD_CYCLES=2, BLINK_FRAMES=2).
module tb_seg_scan_driver;

  localparam int SD    = 8;
  localparam int DC    = 2;
  localparam int FRAME = 4 * SD;

  logic       clk;
  logic       reset_n;
  logic [7:0] digit0, digit1, digit2, digit3;
  logic [3:0] raw_mask, dp_in, blank, blink;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_start;

  int checks   = 0;
  int failures = 0;

  // Expected active-low segments/dp per digit for the frame being checked
  logic [3:0][6:0] e_seg;
  logic [3:0]      e_dp;

  typedef struct {
    logic [7:0]      d0, d1, d2, d3;
    logic [3:0]      raw, dpi, blk, bli;
    logic [3:0][6:0] seg;
    logic [3:0]      dpn;
  } vec_t;

  vec_t vecs [5];

  seg_scan_driver #(
    .SCAN_DIV     (8),
    .DEAD_CYCLES  (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .digit0      (digit0),
    .digit1      (digit1),
    .digit2      (digit2),
    .digit3      (digit3),
    .raw_mask    (raw_mask),
    .dp_in       (dp_in),
    .blank       (blank),
    .blink       (blink),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int cyc, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    digit0   = v.d0;
    digit1   = v.d1;
    digit2   = v.d2;
    digit3   = v.d3;
    raw_mask = v.raw;
    dp_in    = v.dpi;
    blank    = v.blk;
    blink    = v.bli;
    e_seg    = v.seg;
    e_dp     = v.dpn;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_an"},  -1, 8'(an),          8'h0F);
    chk({tag, "_seg"}, -1, 8'(seg),         8'h7F);
    chk({tag, "_dp"},  -1, 8'(dp),          8'h01);
    chk({tag, "_fs"},  -1, 8'(frame_start), 8'h00);
  endtask

  // One clock of a frame; j=1 is the edge that takes the snapshot
  task automatic step_check(input int j);
    int         s, c, d;
    logic [3:0] xa;
    logic [6:0] xs;
    logic       xd;
    @(posedge clk);
    #1;
    s = j - 1;
    c = s % SD;
    d = s / SD;
    if (c < DC) begin
      xa = 4'hF;
      xs = 7'h7F;
      xd = 1'b1;
    end else begin
      xa = 4'(~(4'b0001 << d));
      xs = e_seg[d];
      xd = e_dp[d];
    end
    chk("an",          j, 8'(an),          8'(xa));
    chk("seg",         j, 8'(seg),         8'(xs));
    chk("dp",          j, 8'(dp),          8'(xd));
    chk("frame_start", j, 8'(frame_start), 8'(s == 0));
  endtask

  task automatic run_frame();
    for (int j = 1; j <= FRAME; j++) step_check(j);
  endtask

  initial begin
    vecs[0] = '{d0:8'h01, d1:8'h02, d2:8'h0A, d3:8'h0F, raw:4'h0, dpi:4'h0, blk:4'h0, bli:4'h0,
                seg:{7'h0E, 7'h08, 7'h24, 7'h79}, dpn:4'hF};
    vecs[1] = '{d0:8'h76, d1:8'h03, d2:8'h04, d3:8'h05, raw:4'b0001, dpi:4'b0001, blk:4'h0, bli:4'h0,
                seg:{7'h12, 7'h19, 7'h30, 7'h09}, dpn:4'b1110};
    vecs[2] = '{d0:8'hF8, d1:8'h0B, d2:8'h0C, d3:8'h0D, raw:4'h0, dpi:4'hF, blk:4'b0010, bli:4'h0,
                seg:{7'h21, 7'h46, 7'h7F, 7'h00}, dpn:4'b0010};
    vecs[3] = '{d0:8'h76, d1:8'h79, d2:8'h40, d3:8'hBF, raw:4'hF, dpi:4'h0, blk:4'h0, bli:4'h0,
                seg:{7'h40, 7'h3F, 7'h06, 7'h09}, dpn:4'hF};
    vecs[4] = '{d0:8'h00, d1:8'h06, d2:8'h09, d3:8'h0E, raw:4'h0, dpi:4'b0100, blk:4'h0, bli:4'h0,
                seg:{7'h06, 7'h10, 7'h02, 7'h40}, dpn:4'b1011};

    // Reset held for 5 clocks
    reset_n = 1'b0;
    apply(vecs[0]);
    repeat (5) begin
      @(posedge clk);
      #1;
      check_reset_vals("rst");
    end
    @(negedge clk);
    reset_n = 1'b1;

    // Table: one full frame per vector, every clock checked
    for (int i = 0; i < 5; i++) begin
      apply(vecs[i]);
      run_frame();
    end

    // Mid-frame change of digit2 while digit1 is shown
    digit0 = 8'h00; digit1 = 8'h00; digit2 = 8'h03; digit3 = 8'h00;
    raw_mask = 4'h0; dp_in = 4'h0; blank = 4'h0; blink = 4'h0;
    e_seg = {7'h40, 7'h30, 7'h40, 7'h40};
    e_dp  = 4'hF;
    for (int j = 1; j <= 12; j++) step_check(j);
    digit2 = 8'h07;
    for (int j = 13; j <= FRAME; j++) step_check(j);
    e_seg = {7'h40, 7'h78, 7'h40, 7'h40};
    run_frame();

    // Asynchronous reset while digit2 is active
    for (int j = 1; j <= 20; j++) step_check(j);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_vals("async");
    digit0 = 8'h05; digit1 = 8'h04; digit2 = 8'h03; digit3 = 8'h08;
    blink  = 4'b1000;
    e_seg  = {7'h00, 7'h30, 7'h19, 7'h12};
    repeat (3) begin
      @(posedge clk);
      #1;
      check_reset_vals("rst2");
    end
    @(negedge clk);
    reset_n = 1'b1;

    // Blink on digit3: frames 1-2 visible, 3-4 dark, 5 visible
    for (int n = 1; n <= 5; n++) begin
      e_seg[3] = ((((n - 1) / 2) % 2) == 0) ? 7'h00 : 7'h7F;
      run_frame();
    end

    // Blank plus blink on digit3: dark in both phases
    blank    = 4'b1000;
    e_seg[3] = 7'h7F;
    run_frame();
    run_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed driver for the board's 4-digit common-anode 7-segment display.
- Sink side of the display interface the game blocks produce: up to four per-digit bytes, each either a hex nibble or a raw segment pattern such as 8'h76 for "H".
- Scans digits with anode dead-time, frame-coherent input capture, per-digit blanking and blinking.
- Replaces ad-hoc scan clocks: runs entirely on the system clock using a clock-enable prescaler.

Parameters:
- SCAN_DIV, 100000: system clocks per digit slot (1 kHz/digit at 100 MHz).
- DEAD_CYCLES, 1000: clocks at the start of each slot with all anodes off. Must be < SCAN_DIV; elaboration error otherwise.
- BLINK_FRAMES, 125: frames per blink-phase toggle (0.5 s at defaults).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset_n  in  1  asynchronous active-low reset.
- digit0  in  8  rightmost digit data.
- digit1  in  8  digit data.
- digit2  in  8  digit data.
- digit3  in  8  leftmost digit data.
- raw_mask  in  4  bit i=1: digit i is a raw pattern, bits[6:0] = gfedcba active-high, bit7 ignored. Bit i=0: digit i shows hex of digit_i[3:0].
- dp_in  in  4  decimal point request per digit, active-high.
- blank  in  4  force digit i dark.
- blink  in  4  digit i dark during the blink-off phase.
- seg  out  7  segments gfedcba, active-low.
- dp  out  1  decimal point, active-low.
- an  out  4  anodes, active-low, an[0] = digit0.
- frame_start  out  1  one-cycle pulse when the input snapshot is taken.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - an=4'hF, seg=7'h7F, dp=1, frame_start=0.
  - slot counter=0, digit index=0, blink counter=0, blink phase=visible.
  - snapshot registers cleared.
- Slot counter cnt runs 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps to 0 and the digit index advances 0→1→2→3→0.
- Snapshot:
  - Taken in the cycle where cnt=0 and the index is 0. This includes the first cycle after reset release.
  - All of digit0..3, raw_mask, dp_in, blank and blink are registered together.
  - frame_start pulses in that same cycle.
  - Input changes mid-frame are invisible until the next snapshot; no tearing.
- Dead time: while cnt < DEAD_CYCLES, next an=4'hF, seg=7'h7F, dp=1.
- Active part of the slot (cnt ≥ DEAD_CYCLES), for digit d:
  - an drives only bit d low.
  - seg = ~pattern, where pattern = raw_mask[d] ? digit_d[6:0] : font(digit_d[3:0]).
  - dp = ~dp_in[d].
  - If blank[d], or (blink[d] and phase=off): seg=7'h7F and dp=1, but the anode is still driven so the scan timing is unchanged.
- Latency: all outputs are registered, one clock after the counter/index state that selects them. With SCAN_DIV=8 and DEAD_CYCLES=2, the first anode goes low 3 clocks after reset release.
- Blink:
  - The blink counter increments at each frame_start.
  - When it reaches BLINK_FRAMES-1, it wraps to 0 and the phase toggles.
  - Phase starts visible.
- Hex font, active-high gfedcba:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- blank and blink both set: blank wins (always dark).
- Reset asserted mid-slot: outputs go to reset values immediately, without waiting for a clock. Scanning restarts at digit0 with a fresh snapshot.
- Never more than one anode low in any cycle. Anode transitions always pass through 4'hF for DEAD_CYCLES clocks (DEAD_CYCLES=0 permitted: no gap).

Decomposition:
- Shared package seg_pkg:
  - SEG_OFF=7'h7F and the 16-entry hex font constant.
  - Raw glyph constants: GLYPH_H=8'h76, GLYPH_E=8'h79, GLYPH_DASH=8'h40.
- Sub-module hex_to_seg7: combinational nibble→active-high gfedcba decoder using the package font.
- Counters, snapshot and output registers stay in seg_scan_driver.

Test Plan:
All scenarios use SCAN_DIV=8, DEAD_CYCLES=2, BLINK_FRAMES=2.
1. reset_n=0 for 5 clocks, then release → an=F, seg=7F, dp=1 during reset. frame_start pulses on the first clock after release. an=4'b1110 from the 3rd clock after release.
2. Hex mode, raw_mask=0, digits 1,2,A,F → active slots show seg=79/24/08/0E on an=E/D/B/7. an=F for exactly 2 clocks at each digit change.
3. raw_mask=4'b0001, digit0=8'h76, dp_in=4'b0001 → digit0 active slot seg=7'h09, dp=0; other digits dp=1.
4. Change digit2 from 3 to 7 while digit1 is being shown → digit2 still shows 7'h30 this frame and 7'h78 only after the next frame_start.
5. blink=4'b1000, digit3=8 → digit3 seg alternates 7'h00 for 2 frames, then 7'h7F for 2 frames. blink+blank on digit3 → always 7'h7F.
6. Assert reset_n=0 mid-slot while digit2 is active → an=F, seg=7F in the same cycle (asynchronous). After release, scanning restarts at digit0 with a new snapshot.
